// File: rtl/mmss_bcd_counter_pkg.sv
// Shared constants for the MM:SS stopwatch/timer: state encodings, digit limits
// and the default one-second timebase.
package mmss_bcd_counter_pkg;

    typedef enum logic [1:0] {
        PAUSED  = 2'd0,
        RUNNING = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [3:0]  SEC_TENS_MAX     = 4'd5;
    localparam logic [3:0]  DIGIT_MAX        = 4'd9;
    localparam logic [15:0] UP_LIMIT         = 16'h9959;
    localparam logic        DIR_UP           = 1'b0;
    localparam logic        DIR_DOWN         = 1'b1;
    localparam int          DEFAULT_TICK_DIV = 100000000;

endpackage

// File: rtl/mmss_bcd_counter_bcd_digit_step.sv
// One BCD digit of the ripple counter: steps up or down by cin and reports the
// wrap to the next digit through cout.
module bcd_digit_step
    import mmss_bcd_counter_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [3:0] max,
    input  logic       dir,
    input  logic       cin,
    output logic [3:0] digit_nxt,
    output logic       cout
);

    always_comb begin
        digit_nxt = digit;
        cout      = 1'b0;
        if (cin) begin
            if (dir == DIR_DOWN) begin
                if (digit == 4'd0) begin
                    digit_nxt = max;
                    cout      = 1'b1;
                end else begin
                    digit_nxt = digit - 4'd1;
                end
            end else begin
                // >= also folds any out-of-range digit back to zero
                if (digit >= max) begin
                    digit_nxt = 4'd0;
                    cout      = 1'b1;
                end else begin
                    digit_nxt = digit + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/mmss_bcd_counter.sv
// MM:SS BCD up/down counting core with a one-second prescaler and a
// PAUSED/RUNNING/DONE control FSM driving the four display digits.
module mmss_bcd_counter
    import mmss_bcd_counter_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       mode_down,
    input  logic       stop,
    input  logic [7:0] preset,
    output logic [3:0] di0,
    output logic [3:0] di1,
    output logic [3:0] di2,
    output logic [3:0] di3,
    output logic       tick,
    output logic       done,
    output logic       running
);

    localparam int PW = $clog2(TICK_DIV);

    function automatic logic [3:0] sat_bcd(input logic [3:0] n);
        return (n > DIGIT_MAX) ? DIGIT_MAX : n;
    endfunction

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          mode_q;
    logic [15:0]   target_q;
    logic          step_en;

    logic [3:0] cur [4];
    logic [3:0] lim [4];
    logic [3:0] nxt [4];
    logic [4:0] carry;

    logic [3:0]  pre_hi, pre_lo;
    logic [15:0] value, step_value;
    logic        presc_wrap, step_wrap;

    assign pre_hi = sat_bcd(preset[7:4]);
    assign pre_lo = sat_bcd(preset[3:0]);

    assign cur[0] = di0;
    assign cur[1] = di1;
    assign cur[2] = di2;
    assign cur[3] = di3;
    assign lim[0] = DIGIT_MAX;
    assign lim[1] = SEC_TENS_MAX;
    assign lim[2] = DIGIT_MAX;
    assign lim[3] = DIGIT_MAX;
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < 4; i++) begin : g_digit
        bcd_digit_step u_step (
            .digit     (cur[i]),
            .max       (lim[i]),
            .dir       (mode_q),
            .cin       (carry[i]),
            .digit_nxt (nxt[i]),
            .cout      (carry[i+1])
        );
    end

    assign value      = {di3, di2, di1, di0};
    assign step_value = {nxt[3], nxt[2], nxt[1], nxt[0]};
    assign presc_wrap = (presc_q == PW'(TICK_DIV - 1));
    // A carry out of the minutes tens would wrap the display; treat it as terminal
    assign step_wrap  = carry[4];

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        step_en = 1'b0;
        case (state_q)
            PAUSED: begin
                if (value == target_q)
                    state_d = DONE;
                else if (!stop)
                    state_d = RUNNING;
            end
            RUNNING: begin
                if (stop) begin
                    state_d = PAUSED;
                end else if (presc_wrap) begin
                    presc_d = '0;
                    step_en = !step_wrap;
                    if (step_wrap || step_value == target_q)
                        state_d = DONE;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            DONE: begin
                presc_d = '0;
            end
            default: begin
                state_d = PAUSED;
                presc_d = '0;
            end
        endcase
        // Reload overrides any step landing in the same cycle
        if (clear) begin
            state_d = PAUSED;
            presc_d = '0;
            step_en = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= PAUSED;
            presc_q  <= '0;
            mode_q   <= DIR_UP;
            target_q <= UP_LIMIT;
            di0      <= 4'd0;
            di1      <= 4'd0;
            di2      <= 4'd0;
            di3      <= 4'd0;
            tick     <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick    <= step_en;
            if (clear) begin
                mode_q <= mode_down;
                di0    <= 4'd0;
                di1    <= 4'd0;
                if (mode_down) begin
                    di2      <= pre_lo;
                    di3      <= pre_hi;
                    target_q <= 16'h0000;
                end else begin
                    di2      <= 4'd0;
                    di3      <= 4'd0;
                    target_q <= ({pre_hi, pre_lo} == 8'h00) ? UP_LIMIT
                                                            : {pre_hi, pre_lo, 8'h00};
                end
            end else if (step_en) begin
                di0 <= nxt[0];
                di1 <= nxt[1];
                di2 <= nxt[2];
                di3 <= nxt[3];
            end
        end
    end

    assign done    = (state_q == DONE);
    assign running = (state_q == RUNNING);

endmodule

// File: tb/tb_mmss_bcd_counter.sv
// Bench for mmss_bcd_counter: directed scenarios plus randomized stimulus, checked
// every cycle against a seconds-based reference model.
module tb_mmss_bcd_counter;

    localparam int TD = 4;
    localparam int M_PAUSED = 0;
    localparam int M_RUN    = 1;
    localparam int M_DONE   = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       mode_down;
    logic       stop;
    logic [7:0] preset;
    logic [3:0] di0, di1, di2, di3;
    logic       tick, done, running;

    int checks = 0;
    int errors = 0;

    // Reference model state: time held as plain seconds
    int m_val, m_tgt, m_presc, m_state;
    bit m_down, m_tick;

    mmss_bcd_counter #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .mode_down (mode_down),
        .stop      (stop),
        .preset    (preset),
        .di0       (di0),
        .di1       (di1),
        .di2       (di2),
        .di3       (di3),
        .tick      (tick),
        .done      (done),
        .running   (running)
    );

    always #5 clk = ~clk;

    function automatic int preset_min(input logic [7:0] p);
        int hi, lo;
        hi = int'(p[7:4]);
        lo = int'(p[3:0]);
        if (hi > 9) hi = 9;
        if (lo > 9) lo = 9;
        return hi * 10 + lo;
    endfunction

    function automatic logic [15:0] exp_bcd(input int secs);
        int mm, ss;
        mm = secs / 60;
        ss = secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic int dig();
        return int'({di3, di2, di1, di0});
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_val   <= 0;
            m_tgt   <= 5999;
            m_presc <= 0;
            m_state <= M_PAUSED;
            m_down  <= 1'b0;
            m_tick  <= 1'b0;
        end else if (clear) begin
            m_down  <= mode_down;
            m_presc <= 0;
            m_state <= M_PAUSED;
            m_tick  <= 1'b0;
            if (mode_down) begin
                m_val <= preset_min(preset) * 60;
                m_tgt <= 0;
            end else begin
                m_val <= 0;
                m_tgt <= (preset_min(preset) == 0) ? 5999 : preset_min(preset) * 60;
            end
        end else begin
            m_tick <= 1'b0;
            case (m_state)
                M_PAUSED: begin
                    if (m_val == m_tgt) m_state <= M_DONE;
                    else if (!stop)     m_state <= M_RUN;
                end
                M_RUN: begin
                    if (stop) begin
                        m_state <= M_PAUSED;
                    end else if (m_presc == TD - 1) begin
                        m_presc <= 0;
                        m_val   <= m_val + (m_down ? -1 : 1);
                        m_tick  <= 1'b1;
                        if (m_val + (m_down ? -1 : 1) == m_tgt) m_state <= M_DONE;
                    end else begin
                        m_presc <= m_presc + 1;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        chk("digits",  dig(),         int'(exp_bcd(m_val)));
        chk("tick",    int'(tick),    int'(m_tick));
        chk("done",    int'(done),    int'(m_state == M_DONE));
        chk("running", int'(running), int'(m_state == M_RUN));
    endtask

    task automatic do_clear(input logic md, input logic [7:0] p);
        mode_down = md;
        preset    = p;
        clear     = 1'b1;
        cyc();
        clear     = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "bench timed out");
    end

    initial begin
        int n, lat, ticks, prev, prev_at_0100, held;
        reset = 1'b1; clear = 1'b0; mode_down = 1'b0; stop = 1'b1; preset = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_digits",  dig(),         0);
        chk("rst_done",    int'(done),    0);
        chk("rst_running", int'(running), 0);
        chk("rst_tick",    int'(tick),    0);
        reset = 1'b0;
        cyc();

        // Up mode to 02:00
        do_clear(1'b0, 8'h02);
        stop = 1'b0;
        n = 0;
        while (!running && n < 10) begin cyc(); n++; end
        lat = 0;
        while (!tick && lat < 20) begin cyc(); lat++; end
        chk("up_first_tick_lat", lat, 4);
        chk("up_first_digits", dig(), 16'h0001);
        prev = dig(); prev_at_0100 = -1; n = 0;
        while (!done && n < 2000) begin
            cyc(); n++;
            if (tick && dig() == 16'h0100) prev_at_0100 = prev;
            if (tick) prev = dig();
        end
        chk("up_carry_from", prev_at_0100, 16'h0059);
        chk("up_done", int'(done), 1);
        chk("up_done_digits", dig(), 16'h0200);
        ticks = 0;
        repeat (20) begin cyc(); if (tick) ticks++; end
        chk("up_no_tick_after_done", ticks, 0);
        chk("up_frozen", dig(), 16'h0200);

        // Down mode from 10:00
        do_clear(1'b1, 8'h10);
        chk("dn_load", dig(), 16'h1000);
        n = 0;
        while (!tick && n < 20) begin cyc(); n++; end
        chk("dn_borrow", dig(), 16'h0959);
        n = 0;
        while (!done && n < 3000) begin cyc(); n++; end
        chk("dn_done", int'(done), 1);
        chk("dn_zero", dig(), 0);

        // Pause with prescaler at 2
        do_clear(1'b0, 8'h05);
        n = 0;
        while (!tick && n < 20) begin cyc(); n++; end
        n = 0;
        while (!(m_state == M_RUN && m_presc == 2) && n < 20) begin cyc(); n++; end
        stop = 1'b1;
        held = dig(); ticks = 0;
        repeat (20) begin cyc(); if (tick) ticks++; end
        chk("pause_ticks", ticks, 0);
        chk("pause_hold", dig(), held);
        stop = 1'b0;
        n = 0;
        while (!running && n < 10) begin cyc(); n++; end
        lat = 0;
        while (!tick && lat < 20) begin cyc(); lat++; end
        chk("resume_lat", lat, 2);

        // Down from 00:00 finishes immediately
        do_clear(1'b1, 8'h00);
        chk("zero_paused_done", int'(done), 0);
        chk("zero_paused_run", int'(running), 0);
        cyc();
        chk("zero_done", int'(done), 1);
        ticks = 0;
        repeat (20) begin cyc(); if (tick) ticks++; end
        chk("zero_no_tick", ticks, 0);

        // Clamped preset, mode toggle during run
        do_clear(1'b1, 8'hA7);
        chk("clamp_load", dig(), 16'h9700);
        cyc();
        mode_down = 1'b0;
        preset = 8'h31;
        n = 0;
        while (!tick && n < 20) begin cyc(); n++; end
        chk("dir_isolated", dig(), 16'h9659);

        // Clear coincident with a step
        n = 0;
        while (!(m_state == M_RUN && m_presc == TD - 1) && n < 20) begin cyc(); n++; end
        do_clear(1'b0, 8'h03);
        chk("clr_tick", int'(tick), 0);
        chk("clr_digits", dig(), 0);

        // Asynchronous reset mid-run at 00:07
        n = 0;
        while (dig() != 16'h0007 && n < 100) begin cyc(); n++; end
        chk("pre_reset_digits", dig(), 16'h0007);
        reset = 1'b1;
        #1;
        chk("async_digits",  dig(),         0);
        chk("async_done",    int'(done),    0);
        chk("async_running", int'(running), 0);
        cyc();
        reset = 1'b0;

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            mode_down = 1'($urandom);
            preset    = 8'($urandom);
            if ($urandom_range(0, 19) == 0) stop = ~stop;
            clear = ($urandom_range(0, 199) == 0);
            cyc();
        end
        clear = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmss_bcd_counter.md
Name: mmss_bcd_counter

Overview:
- Timebase and BCD MM:SS counting core that feeds the four 7-segment digit decoders of the stopwatch/timer top.
- Runs in one of two modes:
  - up mode: stopwatch, counts from 00:00 toward a target.
  - down mode: timer, counts from a preset toward 00:00.
- Outputs four BCD digits plus status. Replaces the separate up/down count blocks with a single driver for di0..di3.

Parameters:
- TICK_DIV, 100000000: clk cycles per 1 s count step (Basys3 100 MHz); must be >= 2.

Ports:
- clk      input   1  system clock, all flops rising-edge.
- reset    input   1  asynchronous, active-high; clears all state.
- clear    input   1  synchronous, active-high; reloads start value, samples mode_down.
- mode_down input  1  0 = up (stopwatch), 1 = down (timer); sampled only on clear.
- stop     input   1  level; 1 = pause, 0 = run.
- preset   input   8  {minutes tens, minutes ones} BCD, from {n1,n0}.
- di0      output  4  seconds ones, 0-9.
- di1      output  4  seconds tens, 0-5.
- di2      output  4  minutes ones, 0-9.
- di3      output  4  minutes tens, 0-9.
- tick     output  1  one-cycle pulse in the cycle the digits change.
- done     output  1  high while in DONE.
- running  output  1  high while in RUNNING.

Behaviour:
- Reset values (async): di0..di3 = 0, tick = 0, done = 0, running = 0, state = PAUSED, prescaler = 0, latched mode = up, target = 99:59.
- Preset sanitising: any preset nibble > 9 is clamped to 9.
- Action on clear:
  - Latch mode_down into mode_q.
  - Prescaler = 0; state = PAUSED.
  - Up mode: digits = 00:00; target = preset:00, or 99:59 if preset == 00.
  - Down mode: digits = preset:00; target = 00:00.
- States and transitions:
  - PAUSED:
    - If value == target -> DONE next cycle (regardless of stop).
    - Else if stop == 0 -> RUNNING.
    - Prescaler holds.
  - RUNNING:
    - If stop == 1 -> PAUSED; prescaler holds its value, no count lost or duplicated.
    - Otherwise prescaler increments each cycle.
    - When prescaler == TICK_DIV-1: prescaler -> 0, digits step by one second, tick = 1 that cycle. If the new value equals target -> DONE.
  - DONE:
    - Digits frozen, done = 1, prescaler held at 0.
    - Exits only via clear or reset.
- Latency: first step occurs exactly TICK_DIV cycles after the first RUNNING cycle with prescaler = 0.
- BCD arithmetic: ripple carry/borrow di0 -> di1 -> di2 -> di3.
  - Increment: di0 wraps 9 -> 0, di1 wraps 5 -> 0, di2 wraps 9 -> 0.
  - Decrement: di0 0 -> 9, di1 0 -> 5, di2 0 -> 9.
  - Never steps past the target; 99:59 in up mode and 00:00 in down mode are always terminal.
- Priority: reset > clear > stop > tick.
  - clear and tick in the same cycle: clear wins, no tick pulse.
  - clear with stop = 0: PAUSED for one cycle, then RUNNING.
- Mode isolation: mode_down and preset changes outside clear have no effect on count or target.
- Outputs are registered; digit outputs never hold a non-BCD value.

Decomposition:
- Shared constants header (stopwatch_defs), used by the top and display controller:
  - State encodings PAUSED = 2'd0, RUNNING = 2'd1, DONE = 2'd2.
  - Digit limits SEC_TENS_MAX = 5, DIGIT_MAX = 9.
  - Default TICK_DIV.
- Sub-module bcd_digit_step (combinational, instanced 4x):
  - Inputs: digit, max, dir, cin.
  - Outputs: next digit, cout.
- Prescaler and FSM stay in this module.

Test Plan (TICK_DIV = 4):
- Reset mid-run at 00:07 -> digits 0000, done = 0, running = 0 immediately (async, no clk edge).
- Up mode, preset = 0x02, clear, stop = 0:
  - First tick 4 cycles after RUNNING entry; 00:59 -> 01:00 on carry.
  - Reaches 02:00 -> done = 1, digits frozen, no further ticks.
- Down mode, preset = 0x10, clear, stop = 0:
  - 10:00 -> 09:59 on first tick (borrow through all digits).
  - Runs to 00:00 -> done = 1.
- Pause: stop = 1 when prescaler = 2 -> digits and prescaler hold for 20 cycles; stop = 0 -> next tick after exactly 2 more cycles.
- Down mode, preset = 0x00, clear -> PAUSED, then DONE the following cycle even with stop = 0; no tick ever.
- Preset = 0xA7 in down mode -> loads 97:00. Toggling mode_down during RUNNING does not change the count direction. clear in the same cycle as a tick -> reload wins, tick = 0.
